// File: rtl/cordic_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative CORDIC core among N_REQ requesters.
// Ports: req/req_x/req_y in, ack/rsp_* out, cordic_* to core, busy/grant_id status; CORDIC_ARB_TIMEOUT_EN adds a WAIT watchdog.
module cordic_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_x,
  input  logic [N_REQ*DW-1:0] req_y,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_angle,
  output logic [DW-1:0]       rsp_mag,
  output logic                rsp_err,
  output logic                cordic_start,
  output logic [DW-1:0]       cordic_x,
  output logic [DW-1:0]       cordic_y,
  input  logic                cordic_done,
  input  logic [DW-1:0]       cordic_angle,
  input  logic [DW-1:0]       cordic_mag,
  output logic                busy,
  output logic [GW-1:0]       grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] win_d;
  logic          win_v_d;
  logic [GW-1:0] idx;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
`endif

  // Scan last+1, last+2, ... with wrap; first set request wins.
  always_comb begin
    win_d   = '0;
    win_v_d = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % N_REQ);
      if (!win_v_d && req[idx]) begin
        win_v_d = 1'b1;
        win_d   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= GW'(N_REQ - 1);
      ack          <= '0;
      rsp_valid    <= '0;
      rsp_angle    <= '0;
      rsp_mag      <= '0;
      cordic_start <= 1'b0;
      cordic_x     <= '0;
      cordic_y     <= '0;
      busy         <= 1'b0;
      grant_id     <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      rsp_err      <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      ack          <= '0;
      rsp_valid    <= '0;
      cordic_start <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (win_v_d) begin
            cordic_x     <= req_x[int'(win_d)*DW +: DW];
            cordic_y     <= req_y[int'(win_d)*DW +: DW];
            grant_id     <= win_d;
            last_q       <= win_d;
            ack[win_d]   <= 1'b1;
            busy         <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          cordic_start <= 1'b1;
          state_q      <= WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
          cnt_q        <= '0;
`endif
        end
        WAIT: begin
          if (cordic_done) begin
            rsp_angle           <= cordic_angle;
            rsp_mag             <= cordic_mag;
            rsp_valid[grant_id] <= 1'b1;
            busy                <= 1'b0;
            state_q             <= IDLE;
`ifdef CORDIC_ARB_TIMEOUT_EN
            rsp_err             <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog: return a zeroed error result.
            rsp_angle           <= '0;
            rsp_mag             <= '0;
            rsp_err             <= 1'b1;
            rsp_valid[grant_id] <= 1'b1;
            busy                <= 1'b0;
            state_q             <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifndef CORDIC_ARB_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule
